// File: rtl/des_key_schedule.sv
// des_key_schedule: iterative DES key schedule. A 64-bit key is reduced by
// PC-1 into C/D halves, then one subkey per clock is produced by rotating
// C/D and applying PC-2. All sixteen subkeys stay registered until the next
// accepted load. In decrypt mode the bank is filled in reverse order so the
// same encrypt datapath runs the inverse cipher.
// Optional feature: define DES_KEY_PARITY_CHECK_EN to reject keys whose bytes
// are not odd parity and to expose the parity_err output.
module des_key_schedule #(
  parameter int CLEAR_ON_LOAD = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        key_load,
  output logic        busy,
  output logic        keys_valid,
  output logic [47:0] Key1,
  output logic [47:0] Key2,
  output logic [47:0] Key3,
  output logic [47:0] Key4,
  output logic [47:0] Key5,
  output logic [47:0] Key6,
  output logic [47:0] Key7,
  output logic [47:0] Key8,
  output logic [47:0] Key9,
  output logic [47:0] Key10,
  output logic [47:0] Key11,
  output logic [47:0] Key12,
  output logic [47:0] Key13,
  output logic [47:0] Key14,
  output logic [47:0] Key15,
  output logic [47:0] Key16
`ifdef DES_KEY_PARITY_CHECK_EN
  ,
  output logic        parity_err
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] GEN  = 1'b1;

  // Bit positions are DES-style: 1 = MSB of the source vector.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  logic [0:0]  state;
  logic [3:0]  rnd;
  logic        mode;
  logic [27:0] c;
  logic [27:0] d;
  logic [47:0] sk [16];
  logic        single_shift;
  logic        load_ok;
  logic        load_bad;
  logic [27:0] c_nx;
  logic [27:0] d_nx;
  logic [3:0]  wr_idx;
  logic [55:0] pc1_key;

  // rnd is 4 bits, so round 16 is encoded as 0; wr_idx is the 0-based bank slot.
  assign single_shift = (rnd == 4'd1) || (rnd == 4'd2) || (rnd == 4'd9) || (rnd == 4'd0);
  assign c_nx         = rotl(c, !single_shift);
  assign d_nx         = rotl(d, !single_shift);
  assign wr_idx       = mode ? (4'd0 - rnd) : (rnd - 4'd1);
  assign pc1_key      = pc1(key_in);
  assign busy         = (state == GEN);

`ifdef DES_KEY_PARITY_CHECK_EN
  function automatic logic odd_parity(input logic [63:0] k);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) ok = ok & (^k[6'(i * 8) +: 8]);
    return ok;
  endfunction

  assign load_ok  = key_load && (state == IDLE) && odd_parity(key_in);
  assign load_bad = key_load && (state == IDLE) && !odd_parity(key_in);

  // Parity flag: set by a rejected load, cleared by a good load or reset.
  always_ff @(posedge clk) begin
    if (!rst_n)        parity_err <= 1'b0;
    else if (load_ok)  parity_err <= 1'b0;
    else if (load_bad) parity_err <= 1'b1;
  end
`else
  // Parity bits are simply dropped when checking is not built in.
  logic parity_unused;
  assign parity_unused = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8],  key_in[0]};
  assign load_ok  = key_load && (state == IDLE);
  assign load_bad = 1'b0;
`endif

  // Control: accept loads in IDLE, count rounds in GEN, flag completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rnd        <= 4'd0;
      mode       <= 1'b0;
      keys_valid <= 1'b0;
    end else if (load_ok) begin
      state      <= GEN;
      rnd        <= 4'd1;
      mode       <= decrypt;
      keys_valid <= 1'b0;
    end else if (load_bad) begin
      keys_valid <= 1'b0;
    end else if (state == GEN) begin
      rnd <= rnd + 4'd1;
      if (rnd == 4'd0) begin
        state      <= IDLE;
        keys_valid <= 1'b1;
      end
    end
  end

  // C/D halves: PC-1 on load, rotated once per round.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c <= '0;
      d <= '0;
    end else if (load_ok) begin
      c <= pc1_key[55:28];
      d <= pc1_key[27:0];
    end else if (state == GEN) begin
      c <= c_nx;
      d <= d_nx;
    end
  end

  // Subkey bank: optionally cleared on load, one slot written per round.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) sk[i] <= '0;
    end else if (load_ok) begin
      if (CLEAR_ON_LOAD != 0) begin
        for (int i = 0; i < 16; i++) sk[i] <= '0;
      end
    end else if (state == GEN) begin
      sk[wr_idx] <= pc2({c_nx, d_nx});
    end
  end

  assign Key1  = sk[0];
  assign Key2  = sk[1];
  assign Key3  = sk[2];
  assign Key4  = sk[3];
  assign Key5  = sk[4];
  assign Key6  = sk[5];
  assign Key7  = sk[6];
  assign Key8  = sk[7];
  assign Key9  = sk[8];
  assign Key10 = sk[9];
  assign Key11 = sk[10];
  assign Key12 = sk[11];
  assign Key13 = sk[12];
  assign Key14 = sk[13];
  assign Key15 = sk[14];
  assign Key16 = sk[15];

endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: directed bench for des_key_schedule with a reference
// model that derives each subkey directly from the key and the cumulative
// rotation, checked against the DUT on every cycle.
module tb_des_key_schedule;

  localparam int CLR = 1;
  localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_A   = 64'h0123456789ABCDEF;
  localparam logic [63:0] KEY_B   = 64'hFEDCBA9876543210;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] key_in = '0;
  logic        decrypt = 1'b0;
  logic        key_load = 1'b0;
  logic        busy;
  logic        keys_valid;
  logic [47:0] k1, k2, k3, k4, k5, k6, k7, k8, k9, k10, k11, k12, k13, k14, k15, k16;
`ifdef DES_KEY_PARITY_CHECK_EN
  logic        parity_err;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  // reference model state
  logic        m_gen = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_mode = 1'b0;
  logic        m_perr = 1'b0;
  logic [63:0] m_key = '0;
  int          m_round = 0;
  logic [47:0] m_sk [1:16];

  des_key_schedule #(.CLEAR_ON_LOAD(CLR)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .decrypt(decrypt), .key_load(key_load),
    .busy(busy), .keys_valid(keys_valid),
    .Key1(k1), .Key2(k2), .Key3(k3), .Key4(k4), .Key5(k5), .Key6(k6), .Key7(k7), .Key8(k8),
    .Key9(k9), .Key10(k10), .Key11(k11), .Key12(k12), .Key13(k13), .Key14(k14),
    .Key15(k15), .Key16(k16)
`ifdef DES_KEY_PARITY_CHECK_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] get_key(input int i);
    case (i)
      1: return k1;   2: return k2;   3: return k3;   4: return k4;
      5: return k5;   6: return k6;   7: return k7;   8: return k8;
      9: return k9;   10: return k10; 11: return k11; 12: return k12;
      13: return k13; 14: return k14; 15: return k15; 16: return k16;
      default: return '0;
    endcase
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] v, input int n);
    logic [27:0] r;
    r = (v << n) | (v >> (28 - n));
    return r;
  endfunction

  // Subkey for a given round straight from the key: PC-1, total rotation, PC-2.
  function automatic logic [47:0] model_subkey(input logic [63:0] key, input int round);
    logic [55:0] cd0;
    logic [55:0] cd;
    logic [47:0] k;
    int tot;
    cd0 = '0;
    k = '0;
    tot = 0;
    for (int j = 0; j < 56; j++) cd0[6'(55 - j)] = key[6'(64 - PC1[j])];
    for (int r = 1; r <= round; r++) tot += SHIFTS[r - 1];
    cd = {rot28(cd0[55:28], tot), rot28(cd0[27:0], tot)};
    for (int j = 0; j < 48; j++) k[6'(47 - j)] = cd[6'(56 - PC2[j])];
    return k;
  endfunction

  function automatic logic key_parity_ok(input logic [63:0] k);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) ok = ok & (^k[6'(i * 8) +: 8]);
    return ok;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model update on each rising edge.
  always @(posedge clk) begin
    logic ok;
    int slot;
    if (!rst_n) begin
      m_gen = 1'b0; m_valid = 1'b0; m_perr = 1'b0; m_mode = 1'b0; m_round = 0;
      for (int i = 1; i <= 16; i++) m_sk[i] = '0;
    end else if (!m_gen && key_load) begin
      ok = 1'b1;
`ifdef DES_KEY_PARITY_CHECK_EN
      ok = key_parity_ok(key_in);
`endif
      m_valid = 1'b0;
      if (!ok) begin
        m_perr = 1'b1;
      end else begin
        m_perr = 1'b0; m_gen = 1'b1; m_round = 1; m_mode = decrypt; m_key = key_in;
        if (CLR != 0) for (int i = 1; i <= 16; i++) m_sk[i] = '0;
      end
    end else if (m_gen) begin
      slot = m_mode ? 17 - m_round : m_round;
      m_sk[slot] = model_subkey(m_key, m_round);
      if (m_round == 16) begin
        m_gen = 1'b0;
        m_valid = 1'b1;
      end
      m_round++;
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_gen));
      check("keys_valid", 64'(keys_valid), 64'(m_valid));
      for (int i = 1; i <= 16; i++)
        check($sformatf("Key%0d", i), 64'(get_key(i)), 64'(m_sk[i]));
`ifdef DES_KEY_PARITY_CHECK_EN
      check("parity_err", 64'(parity_err), 64'(m_perr));
`endif
    end
  end

  task automatic do_load(input logic [63:0] key, input logic dec);
    key_in = key;
    decrypt = dec;
    key_load = 1'b1;
    @(posedge clk);
    #1;
    key_load = 1'b0;
    key_in = {$urandom, $urandom};
    decrypt = ~dec;
  endtask

  task automatic wait_valid(input int start, output int cyc);
    cyc = start;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (keys_valid) break;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int cyc;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(keys_valid), 64'd0);
    check("rst_key1", 64'(k1), 64'd0);
    check("rst_key16", 64'(k16), 64'd0);

    // pin the model against published subkeys
    check("model_k1", 64'(model_subkey(KEY_STD, 1)), 64'h1B02EFFC7072);
    check("model_k2", 64'(model_subkey(KEY_STD, 2)), 64'h79AED9DBC9E5);
    check("model_k16", 64'(model_subkey(KEY_STD, 16)), 64'hCB3D8B0E17F5);

    // encrypt vector
    do_load(KEY_STD, 1'b0);
    check("enc_busy", 64'(busy), 64'd1);
    wait_valid(0, cyc);
    check("enc_latency", 64'(cyc), 64'd16);
    check("enc_key1", 64'(k1), 64'h1B02EFFC7072);
    check("enc_key2", 64'(k2), 64'h79AED9DBC9E5);
    check("enc_key16", 64'(k16), 64'hCB3D8B0E17F5);

    // decrypt vector
    do_load(KEY_STD, 1'b1);
    wait_valid(0, cyc);
    check("dec_latency", 64'(cyc), 64'd16);
    check("dec_key1", 64'(k1), 64'hCB3D8B0E17F5);
    check("dec_key15", 64'(k15), 64'h79AED9DBC9E5);
    check("dec_key16", 64'(k16), 64'h1B02EFFC7072);

    // load request during generation is ignored
    do_load(KEY_A, 1'b0);
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 4) begin
        key_in = KEY_B;
        key_load = 1'b1;
      end
      if (cyc == 6) key_load = 1'b0;
      if (keys_valid) break;
    end
    check("gen_load_latency", 64'(cyc), 64'd16);
    check("gen_load_key1", 64'(k1), 64'(model_subkey(KEY_A, 1)));
    check("gen_load_key16", 64'(k16), 64'(model_subkey(KEY_A, 16)));

    // reset in the middle of generation
    do_load(KEY_A, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    pulse_reset();
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(keys_valid), 64'd0);
    for (int i = 1; i <= 16; i++) check($sformatf("midrst_key%0d", i), 64'(get_key(i)), 64'd0);
    do_load(KEY_STD, 1'b0);
    wait_valid(0, cyc);
    check("after_rst_latency", 64'(cyc), 64'd16);
    check("after_rst_key1", 64'(k1), 64'h1B02EFFC7072);

    // reload while valid
    do_load(KEY_A, 1'b0);
    wait_valid(0, cyc);
    check("keyA_latency", 64'(cyc), 64'd16);
    do_load(KEY_STD, 1'b0);
    check("reload_valid_drop", 64'(keys_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reload_mid_key1", 64'(k1), 64'h1B02EFFC7072);
    check("reload_mid_key10", 64'(k10), 64'd0);
    check("reload_mid_key16", 64'(k16), 64'd0);
    wait_valid(3, cyc);
    check("reload_latency", 64'(cyc), 64'd16);
    check("reload_key16", 64'(k16), 64'hCB3D8B0E17F5);

`ifdef DES_KEY_PARITY_CHECK_EN
    // parity rejection then recovery
    pulse_reset();
    do_load(64'h133457799BBCDFF0, 1'b0);
    check("par_err_set", 64'(parity_err), 64'd1);
    check("par_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("par_busy_later", 64'(busy), 64'd0);
    check("par_valid_later", 64'(keys_valid), 64'd0);
    do_load(KEY_STD, 1'b0);
    check("par_err_clear", 64'(parity_err), 64'd0);
    wait_valid(0, cyc);
    check("par_latency", 64'(cyc), 64'd16);
    check("par_key1", 64'(k1), 64'h1B02EFFC7072);
`endif

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Iterative DES key schedule: takes a 64-bit key and produces the sixteen 48-bit round subkeys Key1..Key16 that feed the 16-round encrypt datapath.
- Sits directly upstream of that datapath; one instance is used per DES stage of the Triple-DES chain.
- Generates one subkey per clock and holds all 16 in registers until the next key load.
- Decrypt mode stores subkeys in reverse order, so the same encrypt datapath performs decryption.

Parameters:
- CLEAR_ON_LOAD, 1: 1 = all subkey registers zeroed when a load is accepted; 0 = registers retain old contents until overwritten.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- key_in  in  64  DES key, bit 1 = MSB; parity bits 8,16,...,64 are dropped by PC-1
- decrypt  in  1  sampled with key_load; 1 = store subkeys in reverse order
- key_load  in  1  request to start generating subkeys from key_in
- busy  out  1  high while generating
- keys_valid  out  1  high when Key1..Key16 are complete and stable
- Key1..Key16  out  48 each  subkey outputs, bit 1 = MSB
- parity_err  out  1  present only with DES_KEY_PARITY_CHECK_EN

Behaviour:
- State machine: IDLE, GEN.
- Registers: C and D (28 bits each), 4-bit round counter rnd (1..16), mode flag, subkey bank sk[1..16].
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, keys_valid=0, rnd=0, C=D=0, all Key outputs=0, parity_err=0.
- Reset has priority over everything and may occur mid-GEN; it aborts generation with no partial valid.
- Load acceptance:
  - key_load=1 in IDLE at edge E0 is accepted.
  - C = PC-1 bits 1..28 of key_in; D = PC-1 bits 29..56.
  - The mode flag captures decrypt.
  - keys_valid -> 0, busy -> 1, rnd -> 1, state -> GEN.
  - If CLEAR_ON_LOAD=1, sk[*] -> 0.
- GEN, each edge Ek (k = 1..16):
  - Shift amount: 1 if rnd is 1, 2, 9 or 16; otherwise 2.
  - C' = C rotated left by the shift amount; D' = D rotated left by the shift amount.
  - C and D take C', D'.
  - Subkey written: PC-2({C',D'}), to sk[rnd] when mode=0 or to sk[17-rnd] when mode=1.
  - rnd increments.
- Completion: at E16, state -> IDLE, busy -> 0, keys_valid -> 1.
- Latency: keys_valid is high 16 cycles after the edge that accepted the load.
- Throughput: one key every 17 cycles when loads are back-to-back.
- key_load during GEN is ignored; no queueing and no restart.
- key_load in IDLE while keys_valid=1 is accepted as a new load; keys_valid drops on that same edge.
- key_in and decrypt are only sampled at the accepting edge; changes during GEN have no effect.
- Key outputs change only on writes, so outputs are stable whenever keys_valid=1.
- Total rotation after 16 rounds is 28, so C and D return to their post-PC-1 values. A bench may check this.

Optional Feature:
- Macro: DES_KEY_PARITY_CHECK_EN.
- Defined:
  - On an accepted load, each key byte (bits 8i-7..8i) is checked for odd parity.
  - Any failing byte sets parity_err=1 and forces state to IDLE with keys_valid=0; no generation occurs and busy stays 0.
  - parity_err clears on the next accepted load with correct parity, or on reset.
- Not defined:
  - The parity_err port and its logic are absent.
  - Parity bits are ignored and every load is accepted.

Test Plan:
- Encrypt vector: key_in=133457799BBCDFF1, decrypt=0, pulse key_load -> busy for 16 cycles, then keys_valid=1 with Key1=1B02EFFC7072, Key2=79AED9DBC9E5, Key16=CB3D8B0E17F5.
- Decrypt vector: same key with decrypt=1 -> Key1=CB3D8B0E17F5, Key15=79AED9DBC9E5, Key16=1B02EFFC7072.
- Load during GEN: load key A, then assert key_load with key B at rnd=5 -> keys_valid still at exactly 16 cycles, with key A subkeys.
- Reset mid-operation: assert rst_n=0 at rnd=8 -> next cycle busy=0, keys_valid=0, all Key outputs 0; a fresh load then completes normally.
- Reload while valid: key A valid, then load 133457799BBCDFF1 -> keys_valid=0 the cycle after the load edge, and after 16 cycles the subkeys match the first test; with CLEAR_ON_LOAD=1, untouched keys read 0 mid-generation.
- Parity (macro on): key_in=133457799BBCDFF0 -> parity_err=1, busy never asserts, keys_valid stays 0; reload with ...F1 -> parity_err=0 and normal completion.
